// File: rtl/iq_magnitude_sqrt_gen.sv
// IQ magnitude unit: squares I and Q, then extracts sqrt(I^2+Q^2) one result bit per cycle,
// with optional round-to-nearest and optional clamp to Q0.(W-1) full scale.
module iq_magnitude_sqrt_gen #(
   parameter int W     = 16,
   parameter bit ROUND = 1'b0,
   parameter bit SAT   = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic signed [W-1:0] I_in,
   input  logic signed [W-1:0] Q_in,
   output logic                busy,
   output logic                done,
   output logic [W-1:0]        magnitude,
   output logic                overflow,
   output logic [2*W-1:0]      sum_squares
);

   typedef enum logic [1:0] {IDLE, SQUARE, ROOT, DONE} state_t;

   localparam int CW = $clog2(W + 1);
   localparam logic [W:0] MAX_POS = {2'b00, {(W-1){1'b1}}};

   state_t              state;
   logic signed [W-1:0] i_reg, q_reg;
   logic [2*W-1:0]      rad;
   logic [W+1:0]        rem;
   logic [W-1:0]        root;
   logic [CW-1:0]       count;

   // Signed multiplies keep -2^(W-1) exact; the sum of two squares never exceeds 2^(2W-1).
   logic signed [2*W-1:0] i_sq, q_sq;
   logic [2*W-1:0]        sq_sum;
   assign i_sq   = i_reg * i_reg;
   assign q_sq   = q_reg * q_reg;
   assign sq_sum = $unsigned(i_sq) + $unsigned(q_sq);

   // One digit-by-digit step: bring down two radicand bits, try subtracting 4r+1.
   logic [W+3:0] rem_sh, trial;
   logic [W+1:0] rem_diff;
   logic         take;
   assign rem_sh   = {rem, rad[2*W-1 -: 2]};
   assign trial    = {2'b00, root, 2'b01};
   assign take     = (rem_sh >= trial);
   assign rem_diff = rem_sh[W+1:0] - trial[W+1:0];

   logic         round_up, sat_hit;
   logic [W:0]   rounded;
   logic [W-1:0] final_mag;
   assign round_up  = ROUND && (rem > {2'b00, root});
   assign rounded   = {1'b0, root} + {{W{1'b0}}, round_up};
   assign sat_hit   = SAT && (rounded > MAX_POS);
   assign final_mag = sat_hit ? MAX_POS[W-1:0] : rounded[W-1:0];

   // ROOT spends W cycles iterating and one more registering the rounded/clamped result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         magnitude   <= '0;
         overflow    <= 1'b0;
         sum_squares <= '0;
         i_reg       <= '0;
         q_reg       <= '0;
         rad         <= '0;
         rem         <= '0;
         root        <= '0;
         count       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  i_reg <= I_in;
                  q_reg <= Q_in;
                  busy  <= 1'b1;
                  state <= SQUARE;
               end
            end
            SQUARE: begin
               sum_squares <= sq_sum;
               rad         <= sq_sum;
               rem         <= '0;
               root        <= '0;
               count       <= CW'(W);
               state       <= ROOT;
            end
            ROOT: begin
               if (count != '0) begin
                  rad   <= {rad[2*W-3:0], 2'b00};
                  rem   <= take ? rem_diff : rem_sh[W+1:0];
                  root  <= {root[W-2:0], take};
                  count <= count - 1'b1;
               end else begin
                  magnitude <= final_mag;
                  overflow  <= sat_hit;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iq_magnitude_sqrt_gen.sv
// Scoreboard bench: six parameter variants; expected results queued at issue, popped on done.
module tb_iq_magnitude_sqrt_gen;

   typedef struct {
      logic [16:0] mag;
      logic        ovf;
      logic [31:0] sum;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start16 = 1'b0, start8 = 1'b0;
   logic signed [15:0] i16 = '0, q16 = '0;
   logic signed [7:0]  i8 = '0, q8 = '0;

   logic [5:0]  done_vec, busy_vec, ovf_vec;
   logic [15:0] act_mag [6];
   logic [31:0] act_sum [6];
   logic [7:0]  mag4, mag5;
   logic [15:0] sum4, sum5;

   exp_t sb [6][$];
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   iq_magnitude_sqrt_gen #(.W(16), .ROUND(1'b0), .SAT(1'b1)) u_r0s1 (
      .clk(clk), .rst(rst), .start(start16), .I_in(i16), .Q_in(q16),
      .busy(busy_vec[0]), .done(done_vec[0]), .magnitude(act_mag[0]),
      .overflow(ovf_vec[0]), .sum_squares(act_sum[0]));
   iq_magnitude_sqrt_gen #(.W(16), .ROUND(1'b1), .SAT(1'b1)) u_r1s1 (
      .clk(clk), .rst(rst), .start(start16), .I_in(i16), .Q_in(q16),
      .busy(busy_vec[1]), .done(done_vec[1]), .magnitude(act_mag[1]),
      .overflow(ovf_vec[1]), .sum_squares(act_sum[1]));
   iq_magnitude_sqrt_gen #(.W(16), .ROUND(1'b0), .SAT(1'b0)) u_r0s0 (
      .clk(clk), .rst(rst), .start(start16), .I_in(i16), .Q_in(q16),
      .busy(busy_vec[2]), .done(done_vec[2]), .magnitude(act_mag[2]),
      .overflow(ovf_vec[2]), .sum_squares(act_sum[2]));
   iq_magnitude_sqrt_gen #(.W(16), .ROUND(1'b1), .SAT(1'b0)) u_r1s0 (
      .clk(clk), .rst(rst), .start(start16), .I_in(i16), .Q_in(q16),
      .busy(busy_vec[3]), .done(done_vec[3]), .magnitude(act_mag[3]),
      .overflow(ovf_vec[3]), .sum_squares(act_sum[3]));
   iq_magnitude_sqrt_gen #(.W(8), .ROUND(1'b0), .SAT(1'b1)) u_w8s1 (
      .clk(clk), .rst(rst), .start(start8), .I_in(i8), .Q_in(q8),
      .busy(busy_vec[4]), .done(done_vec[4]), .magnitude(mag4),
      .overflow(ovf_vec[4]), .sum_squares(sum4));
   iq_magnitude_sqrt_gen #(.W(8), .ROUND(1'b0), .SAT(1'b0)) u_w8s0 (
      .clk(clk), .rst(rst), .start(start8), .I_in(i8), .Q_in(q8),
      .busy(busy_vec[5]), .done(done_vec[5]), .magnitude(mag5),
      .overflow(ovf_vec[5]), .sum_squares(sum5));

   assign act_mag[4] = {8'h00, mag4};
   assign act_mag[5] = {8'h00, mag5};
   assign act_sum[4] = {16'h0000, sum4};
   assign act_sum[5] = {16'h0000, sum5};

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Any done pulse must match the oldest queued expectation; a done with nothing queued is an error.
   always @(negedge clk) begin
      for (int n = 0; n < 6; n++) begin
         if (done_vec[n]) begin
            if (sb[n].size() == 0) begin
               checkOutput($sformatf("dut%0d unexpected done", n), 0, 1);
            end else begin
               exp_t e;
               e = sb[n].pop_front();
               checkOutput($sformatf("dut%0d magnitude", n), act_mag[n], e.mag);
               checkOutput($sformatf("dut%0d overflow", n), ovf_vec[n], e.ovf);
               checkOutput($sformatf("dut%0d sum_squares", n), act_sum[n], e.sum);
            end
         end
      end
   end

   function automatic exp_t makeExp(input int mag, input int max_pos, input bit sat,
                                    input logic [31:0] sum);
      exp_t e;
      e.sum = sum;
      e.ovf = sat && (mag > max_pos);
      e.mag = e.ovf ? 17'(max_pos) : 17'(mag);
      return e;
   endfunction

   // fl/rn are hand-computed floor and round-to-nearest square roots; poke>0 re-pulses start mid-op.
   task automatic applyStimulus(input logic signed [15:0] i_val, input logic signed [15:0] q_val,
                                input logic [31:0] sum, input int fl, input int rn, input int poke);
      int cyc;
      sb[0].push_back(makeExp(fl, 32767, 1'b1, sum));
      sb[1].push_back(makeExp(rn, 32767, 1'b1, sum));
      sb[2].push_back(makeExp(fl, 32767, 1'b0, sum));
      sb[3].push_back(makeExp(rn, 32767, 1'b0, sum));
      @(negedge clk);
      i16 = i_val; q16 = q_val; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      checkOutput("busy after accept", busy_vec[0], 1);
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == poke) begin
            start16 = 1'b1; i16 = 16'sd6; q16 = 16'sd8;
         end else begin
            start16 = 1'b0;
         end
      end while (!done_vec[0] && cyc < 40);
      start16 = 1'b0;
      checkOutput("w16 done latency", cyc, 18);
      checkOutput("busy during done", busy_vec[0], 1);
      @(posedge clk); #1;
      checkOutput("busy after done", busy_vec[0], 0);
      checkOutput("done single pulse", done_vec[0], 0);
   endtask

   task automatic applyStimulus8(input logic signed [7:0] i_val, input logic signed [7:0] q_val,
                                 input logic [31:0] sum, input int fl);
      int cyc;
      sb[4].push_back(makeExp(fl, 127, 1'b1, sum));
      sb[5].push_back(makeExp(fl, 127, 1'b0, sum));
      @(negedge clk);
      i8 = i_val; q8 = q_val; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!done_vec[4] && cyc < 30);
      checkOutput("w8 done latency", cyc, 10);
      @(posedge clk); #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset busy", busy_vec[0], 0);
      checkOutput("reset done", done_vec[0], 0);
      checkOutput("reset magnitude", act_mag[0], 0);
      checkOutput("reset overflow", ovf_vec[0], 0);
      checkOutput("reset sum_squares", act_sum[0], 0);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(16'sd3, 16'sd4, 32'd25, 5, 5, 0);
      applyStimulus(16'sd10000, 16'sd20000, 32'd500000000, 22360, 22361, 0);
      applyStimulus(16'sd32767, 16'sd32767, 32'h7FFE0002, 46339, 46340, 0);
      applyStimulus(-16'sd32768, 16'sd0, 32'h40000000, 32768, 32768, 0);
      applyStimulus(16'sd0, 16'sd0, 32'd0, 0, 0, 0);

      // Start re-pulsed with (6,8) mid-ROOT is ignored; the in-flight (3,4) still yields 5.
      applyStimulus(16'sd3, 16'sd4, 32'd25, 5, 5, 7);
      applyStimulus(16'sd6, 16'sd8, 32'd100, 10, 10, 0);

      // Abort five cycles into ROOT; nothing is queued, so any done pulse is flagged.
      @(negedge clk);
      i16 = 16'sd3; q16 = 16'sd4; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("abort busy", busy_vec[0], 0);
      checkOutput("abort done", done_vec[0], 0);
      checkOutput("abort magnitude", act_mag[0], 0);
      checkOutput("abort sum_squares", act_sum[0], 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (25) @(negedge clk);
      applyStimulus(-16'sd6, 16'sd8, 32'd100, 10, 10, 0);

      applyStimulus8(8'sd3, 8'sd4, 32'd25, 5);
      applyStimulus8(8'sd127, 8'sd127, 32'd32258, 179);
      applyStimulus8(-8'sd128, 8'sd0, 32'd16384, 128);

      repeat (3) @(negedge clk);
      for (int n = 0; n < 6; n++)
         checkOutput($sformatf("dut%0d pending results", n), sb[n].size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
